// File: rtl/error_freq_deviation_too_high_pkg.sv
// Shared definitions for the divider-setting checker: FSM states, step
// counts, scaling constants and a saturation helper.
package error_freq_deviation_too_high_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DIV_Q   = 3'd1,
        DIV_ACT = 3'd2,
        DIV_PPM = 3'd3,
        FIN     = 3'd4
    } state_e;

    // Cycles spent in each division step (one quotient bit per cycle).
    localparam int DIV_STEPS = 64;
    // Parts-per-million scale factor for the deviation result.
    localparam int PPM_SCALE = 1_000_000;
    // Rising edges from the accepting edge to the edge that samples done.
    localparam int LATENCY   = 194;

    // Clamp a 64-bit value into 32 bits.
    function automatic logic [31:0] sat32(input logic [63:0] v);
        return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

endpackage

// File: rtl/error_freq_deviation_too_high_seq_div64.sv
// 64-bit radix-2 restoring divider, one quotient bit per enabled cycle.
// start_i loads the operands and performs the first step in the same cycle,
// so 64 enabled cycles starting with start_i leave the final quotient.
// A zero divisor yields a zero quotient.
module seq_div64 (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [63:0] dividend_i,
    input  logic [63:0] divisor_i,
    output logic [63:0] quotient_o
);

    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dvsr_q;

    logic [63:0] rem_in;
    logic [63:0] quo_in;
    logic [63:0] dvsr_in;
    logic [64:0] rem_sh;
    logic [63:0] rem_d;
    logic [63:0] quo_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        // NOTE: every combinational output gets a value on every path first; a missed branch would infer a latch.
        rem_in  = start_i ? 64'd0 : rem_q;
        quo_in  = start_i ? dividend_i : quo_q;
        dvsr_in = start_i ? divisor_i : dvsr_q;
        rem_sh  = {rem_in, quo_in[63]};
        rem_d   = rem_sh[63:0];
        quo_d   = {quo_in[62:0], 1'b0};
        if (rem_sh >= {1'b0, dvsr_in}) begin
            rem_d = 64'(rem_sh - {1'b0, dvsr_in});
            quo_d = {quo_in[62:0], 1'b1};
        end
    end

    // Advance the division while enabled; hold the result otherwise.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
        end else if (start_i || en_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_in;
        end
    end

    assign quotient_o = (dvsr_q == 64'd0) ? 64'd0 : quo_q;

endmodule

// File: rtl/error_freq_deviation_too_high.sv
// Run-time checker for an integer clock divider: from a requested frequency
// it derives the reload value, the achieved frequency and the upward ppm
// deviation using three sequential 64-cycle divisions on one shared divider.
module error_freq_deviation_too_high
    import error_freq_deviation_too_high_pkg::*;
#(
    parameter int unsigned FREQ_I  = 12_000_000,
    parameter int unsigned MAX_PPM = 50_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] freq_o,
    output logic        busy,
    output logic        done,
    output logic [31:0] init_o,
    output logic [31:0] actual_o,
    output logic [31:0] ppm_o,
    output logic        err_too_high,
    output logic        err_deviation
);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] freq_q;
    logic [63:0] h_q;
    logic [63:0] act_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] init_q;
    logic [31:0] actual_q;
    logic [31:0] ppm_q;
    logic        too_high_q;
    logic        deviation_q;

    logic        div_en;
    logic        div_start;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic [63:0] div_quo;
    logic [63:0] ppm_diff;
    logic [31:0] ppm_sat;

    // Operand selection: each step reads the previous step's quotient while
    // it is still held in the divider during the step's first cycle.
    always_comb begin
        div_en       = (state_q == DIV_Q) || (state_q == DIV_ACT) || (state_q == DIV_PPM);
        div_start    = div_en && (cnt_q == 6'd0);
        div_dividend = 64'(FREQ_I);
        div_divisor  = {32'd0, freq_q};
        ppm_diff     = 64'd0;
        case (state_q)
            DIV_ACT: div_divisor = {div_quo[63:1], 1'b0};  // 2h from q
            DIV_PPM: begin
                // Unsigned difference, clamped so an h == 0 path never wraps.
                ppm_diff     = (div_quo >= {32'd0, freq_q}) ? div_quo - {32'd0, freq_q} : 64'd0;
                div_dividend = 64'(64'(PPM_SCALE) * ppm_diff);
            end
            default: ;
        endcase
    end

    assign ppm_sat = sat32(div_quo);

    seq_div64 u_div (
        .clk        (clk),
        .rst_i      (reset),
        .start_i    (div_start),
        .en_i       (div_en),
        .dividend_i (div_dividend),
        .divisor_i  (div_divisor),
        .quotient_o (div_quo)
    );

    // Control FSM with registered busy/done and result registers updated in FIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            freq_q      <= '0;
            h_q         <= '0;
            act_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            init_q      <= '0;
            actual_q    <= '0;
            ppm_q       <= '0;
            too_high_q  <= 1'b0;
            deviation_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        freq_q  <= freq_o;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DIV_Q;
                    end
                end
                DIV_Q, DIV_ACT, DIV_PPM: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (state_q == DIV_ACT && cnt_q == 6'd0) h_q   <= div_quo >> 1;
                    if (state_q == DIV_PPM && cnt_q == 6'd0) act_q <= div_quo;
                    if (cnt_q == 6'(DIV_STEPS - 1)) begin
                        case (state_q)
                            DIV_Q:   state_q <= DIV_ACT;
                            DIV_ACT: state_q <= DIV_PPM;
                            default: state_q <= FIN;
                        endcase
                    end
                end
                FIN: begin
                    if (freq_q == 32'd0) begin
                        init_q      <= '0;
                        actual_q    <= '0;
                        ppm_q       <= '0;
                        too_high_q  <= 1'b1;
                        deviation_q <= 1'b1;
                    end else if (h_q == 64'd0) begin
                        init_q      <= '0;
                        actual_q    <= '0;
                        ppm_q       <= '0;
                        too_high_q  <= 1'b1;
                        deviation_q <= 1'b0;
                    end else begin
                        init_q      <= sat32(h_q - 64'd1);
                        actual_q    <= sat32(act_q);
                        ppm_q       <= ppm_sat;
                        too_high_q  <= 1'b0;
                        deviation_q <= (ppm_sat > 32'(MAX_PPM));
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign init_o        = init_q;
    assign actual_o      = actual_q;
    assign ppm_o         = ppm_q;
    assign err_too_high  = too_high_q;
    assign err_deviation = deviation_q;

endmodule

// File: tb/tb_error_freq_deviation_too_high.sv
// Self-checking bench: fixed vectors, randomized frequencies against an
// arithmetic reference model, restart/abort and back-to-back scenarios.
module tb_error_freq_deviation_too_high;

    localparam int unsigned FREQ_I  = 12_000_000;
    localparam int unsigned MAX_PPM = 50_000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] freq_o;
    logic        busy;
    logic        done;
    logic [31:0] init_o;
    logic [31:0] actual_o;
    logic [31:0] ppm_o;
    logic        err_too_high;
    logic        err_deviation;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] init;
        logic [31:0] act;
        logic [31:0] ppm;
        logic        th;
        logic        dev;
    } res_t;

    error_freq_deviation_too_high #(.FREQ_I(FREQ_I), .MAX_PPM(MAX_PPM)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .freq_o        (freq_o),
        .busy          (busy),
        .done          (done),
        .init_o        (init_o),
        .actual_o      (actual_o),
        .ppm_o         (ppm_o),
        .err_too_high  (err_too_high),
        .err_deviation (err_deviation)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic straight from the rules.
    function automatic res_t model(input logic [31:0] f);
        res_t r;
        longint unsigned q, h, a, p;
        r = '0;
        if (f == 32'd0) begin
            r.th = 1'b1;
            r.dev = 1'b1;
            return r;
        end
        q = longint'(FREQ_I) / longint'(f);
        h = q / 2;
        if (h == 0) begin
            r.th = 1'b1;
            return r;
        end
        a = longint'(FREQ_I) / (2 * h);
        p = (64'd1_000_000 * (a - longint'(f))) / longint'(f);
        r.init = 32'(h - 1);
        r.act  = 32'(a);
        r.ppm  = (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(p);
        r.dev  = (r.ppm > MAX_PPM);
        return r;
    endfunction

    function automatic res_t observed();
        return {init_o, actual_o, ppm_o, err_too_high, err_deviation};
    endfunction

    // Issue one request; report on which edge done was sampled high (edges
    // counted from the accepting edge), how many done pulses appeared, busy
    // misbehaviour, and the outputs seen mid-computation.
    task automatic run_req(input logic [31:0] f, input int repulse_at, input int max_k,
                           output int done_edge, output int n_done, output int busy_bad,
                           output res_t mid);
        @(negedge clk);
        freq_o = f;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        freq_o = $urandom();
        done_edge = -1;
        n_done    = 0;
        busy_bad  = 0;
        mid       = '0;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = k;
            end
            if (busy !== (k <= 193)) busy_bad++;
            if (k == 100) mid = observed();
            start  = (k == repulse_at);
            if (k == repulse_at) freq_o = $urandom_range(1, 100_000);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        freq_o = 32'd0;
        #1;
        n_checks++;
        if ({busy, done, observed()} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 0", {busy, done, observed()});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({busy, done, observed()} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected 0", {busy, done, observed()});
        end
    endtask

    task automatic test_vectors();
        logic [31:0] fv [5] = '{32'd28_800, 32'd12_000_000, 32'd6_000_000, 32'd5_000_000, 32'd0};
        res_t        ev [5];
        int de, nd, bb;
        res_t mid;
        ev[0] = '{init: 32'd207, act: 32'd28_846,    ppm: 32'd1_597,   th: 1'b0, dev: 1'b0};
        ev[1] = '{init: 32'd0,   act: 32'd0,         ppm: 32'd0,       th: 1'b1, dev: 1'b0};
        ev[2] = '{init: 32'd0,   act: 32'd6_000_000, ppm: 32'd0,       th: 1'b0, dev: 1'b0};
        ev[3] = '{init: 32'd0,   act: 32'd6_000_000, ppm: 32'd200_000, th: 1'b0, dev: 1'b1};
        ev[4] = '{init: 32'd0,   act: 32'd0,         ppm: 32'd0,       th: 1'b1, dev: 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_req(fv[i], -1, 220, de, nd, bb, mid);
            n_checks++;
            if (de != 194 || nd != 1) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got edge %0d pulses %0d expected edge 194 pulses 1", i, de, nd);
            end
            n_checks++;
            if (observed() !== ev[i]) begin
                n_fail++;
                $display("FAIL vec%0d_result: got %h expected %h", i, observed(), ev[i]);
            end
            n_checks++;
            if (bb != 0) begin
                n_fail++;
                $display("FAIL vec%0d_busy: got %0d bad cycles expected 0", i, bb);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] f;
        res_t prev, exp_r, mid;
        int de, nd, bb;
        prev = observed();
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 4))
                0: f = $urandom_range(1, 2_000);
                1: f = $urandom_range(1_000, 3_000_000);
                2: f = $urandom_range(3_000_000, 13_000_000);
                3: f = $urandom();
                default: f = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom_range(20_000, 400_000);
            endcase
            exp_r = model(f);
            run_req(f, -1, 200, de, nd, bb, mid);
            n_checks++;
            if (observed() !== exp_r) begin
                n_fail++;
                $display("FAIL rand%0d_result f=%0d: got %h expected %h", i, f, observed(), exp_r);
            end
            n_checks++;
            if (mid !== prev) begin
                n_fail++;
                $display("FAIL rand%0d_hold: got %h expected %h", i, mid, prev);
            end
            n_checks++;
            if (de != 194 || nd != 1 || bb != 0) begin
                n_fail++;
                $display("FAIL rand%0d_timing: got edge %0d pulses %0d busybad %0d expected 194 1 0", i, de, nd, bb);
            end
            prev = exp_r;
        end
    endtask

    task automatic test_restart_ignored();
        int at [2] = '{50, 193};
        int de, nd, bb;
        res_t mid;
        for (int i = 0; i < 2; i++) begin
            run_req(32'd28_800 + 32'(i * 1000), at[i], 230, de, nd, bb, mid);
            n_checks++;
            if (de != 194 || nd != 1) begin
                n_fail++;
                $display("FAIL restart%0d_done: got edge %0d pulses %0d expected 194 1", at[i], de, nd);
            end
            n_checks++;
            if (observed() !== model(32'd28_800 + 32'(i * 1000))) begin
                n_fail++;
                $display("FAIL restart%0d_result: got %h expected %h", at[i], observed(),
                         model(32'd28_800 + 32'(i * 1000)));
            end
            n_checks++;
            if (bb != 0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL restart%0d_busy: got busybad %0d busy %b expected 0 0", at[i], bb, busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        int nd = 0;
        int de, bb;
        res_t mid;
        @(negedge clk);
        freq_o = 32'd28_800;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, observed()} !== '0) begin
            n_fail++;
            $display("FAIL abort_clear: got %h expected 0", {busy, done, observed()});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_checks++;
        if (nd != 0 || {busy, observed()} !== '0) begin
            n_fail++;
            $display("FAIL abort_nodone: got pulses %0d state %h expected 0 0", nd, {busy, observed()});
        end
        run_req(32'd5_000_000, -1, 200, de, nd, bb, mid);
        n_checks++;
        if (de != 194 || nd != 1 || observed() !== model(32'd5_000_000)) begin
            n_fail++;
            $display("FAIL abort_recover: got edge %0d result %h expected 194 %h", de, observed(),
                     model(32'd5_000_000));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] fs [3] = '{32'd115_200, 32'd1, 32'd4_000_000};
        int de, nd, bb;
        res_t mid;
        for (int i = 0; i < 3; i++) begin
            run_req(fs[i], -1, 194, de, nd, bb, mid);
            n_checks++;
            if (de != 194 || observed() !== model(fs[i])) begin
                n_fail++;
                $display("FAIL b2b%0d: got edge %0d result %h expected 194 %h", i, de, observed(), model(fs[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_restart_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/error_freq_deviation_too_high.md
ERROR_FREQ_DEVIATION_TOO_HIGH -- requirements
Module: error_freq_deviation_too_high

Purpose: run-time checker for integer clock-divider settings. Flags a requested output frequency that is too high for the input clock, and flags excessive rounding deviation in ppm.

Interface
REQ-001 SHALL have parameter FREQ_I, default 12_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter MAX_PPM, default 50_000, meaning maximum permitted upward deviation in ppm.
REQ-003 SHALL have the port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have the port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have the port start, input, 1 bit, meaning a request strobe.
REQ-006 SHALL have the port freq_o, input, 32 bits, meaning the requested output frequency in Hz (unsigned).
REQ-007 SHALL have the port busy, output, 1 bit, meaning a computation is in progress.
REQ-008 SHALL have the port done, output, 1 bit, meaning a one-cycle pulse marking results valid.
REQ-009 SHALL have the port init_o, output, 32 bits, meaning the divider reload value INIT.
REQ-010 SHALL have the port actual_o, output, 32 bits, meaning the achieved frequency in Hz.
REQ-011 SHALL have the port ppm_o, output, 32 bits, meaning the deviation in ppm (saturated at 2^32-1).
REQ-012 SHALL have the port err_too_high, output, 1 bit, meaning the requested frequency is unreachable.
REQ-013 SHALL have the port err_deviation, output, 1 bit, meaning ppm_o > MAX_PPM.

Function
REQ-014 SHALL use states IDLE, DIV_Q, DIV_ACT, DIV_PPM and FIN; transitions are IDLE->DIV_Q on start, each DIV_x->next after exactly 64 cycles, and FIN->IDLE after 1 cycle.
REQ-015 SHALL capture freq_o when start is high in IDLE; start is ignored while busy.
REQ-016 SHALL drive busy high in every non-IDLE state.
REQ-017 SHALL pulse done for exactly 1 cycle in FIN; done SHALL be sampled high at the 194th rising edge after the start edge.
REQ-018 DIV_Q SHALL compute q = floor(FREQ_I / F) and h = q >> 1.
REQ-019 If h == 0 then err_too_high=1, err_deviation=0, and init_o=actual_o=ppm_o=0.
REQ-020 If h > 0 then init_o = h-1, DIV_ACT SHALL compute actual_o = floor(FREQ_I / (2h)), and DIV_PPM SHALL compute ppm_o = floor(1_000_000*(actual_o-F)/F) using a 64-bit intermediate.
REQ-021 If h > 0 then err_deviation = (ppm_o > MAX_PPM) and err_too_high=0.
REQ-022 If F == 0 then err_too_high=1, err_deviation=1 and all numeric outputs are 0; the divider SHALL NOT fault, and latency is unchanged.
REQ-023 Divisions without a valid divisor SHALL still consume their 64 cycles so that latency is constant.
REQ-024 Results and flags SHALL update only in FIN and hold until the next FIN.
REQ-025 actual_o >= F holds whenever h > 0; the subtraction SHALL be unsigned with no wrap.
REQ-026 start asserted in the FIN cycle SHALL be ignored; a new request is accepted from IDLE only.

Reset
REQ-027 reset SHALL force IDLE and clear busy, done, init_o, actual_o, ppm_o, err_too_high and err_deviation to 0, asynchronously.
REQ-028 reset asserted mid-computation SHALL abort it with no done pulse; after release the block SHALL accept start normally.

Structure
REQ-029 A shared package SHALL hold the state enum, DIV_STEPS=64, PPM_SCALE=1_000_000 and the latency constant 194.
REQ-030 One sub-module, seq_div64, SHALL implement a 64-bit radix-2 restoring divider (1 bit/cycle, divide-by-zero returns 0) and be reused by all three steps.

Verification
REQ-031 F=28_800 -> init_o=207, actual_o=28_846, ppm_o=1_597, both errors 0, done at edge 194.
REQ-032 F=12_000_000 -> err_too_high=1, err_deviation=0, init_o=0.
REQ-033 F=6_000_000 -> init_o=0, actual_o=6_000_000, ppm_o=0, no errors; F=5_000_000 -> ppm_o=200_000, err_deviation=1.
REQ-034 F=0 -> both errors 1, numeric outputs 0, done at edge 194.
REQ-035 Start re-pulsed at cycle 50 -> ignored, single done at 194; reset at cycle 100 -> no done, outputs 0, next start completes normally.
